n64_bank_responder: RTL and testbench

//  Return path for decoded N64 PI accesses: takes a request already bank-decoded (bank, translated address,

---
 rtl/n64_bank_responder.sv | 216 +++++++++++++++++++++
 tb/tb_n64_bank_responder.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/n64_bank_responder.sv
// Return path for bank-decoded N64 PI accesses: drives the selected bank's req/ack handshake,
// returns data/ack to the PI side, and keeps a one-word sequential prefetch buffer.
module n64_bank_responder #(
  parameter int unsigned NUM_BANKS      = 4,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                    i_clk,
  input  logic                    i_reset_n,
  input  logic                    i_request,
  input  logic                    i_write,
  input  logic [25:0]             i_address,
  input  logic [3:0]              i_bank,
  input  logic                    i_prefetch,
  input  logic [15:0]             i_wdata,
  output logic                    o_ack,
  output logic [15:0]             o_rdata,
  output logic                    o_timeout,
  output logic [NUM_BANKS-1:0]    o_bank_request,
  output logic                    o_bank_write,
  output logic [25:0]             o_bank_address,
  output logic [15:0]             o_bank_wdata,
  input  logic [NUM_BANKS-1:0]    i_bank_ack,
  input  logic [16*NUM_BANKS-1:0] i_bank_rdata
);

  localparam logic [7:0] TimeoutCnt = 8'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {StIdle, StAccess, StRespond, StPrefetch} state_e;

  state_e r_state, w_state_next;

  logic                 r_pend, r_write, r_pref, r_inv;
  logic [24:0]          r_word;
  logic [3:0]           r_bank, r_sel;
  logic [15:0]          r_wdata, r_resp_data;
  logic [7:0]           r_cnt;
  logic                 r_buf_valid;
  logic [3:0]           r_buf_bank;
  logic [24:0]          r_buf_word;
  logic [15:0]          r_buf_data;
  logic                 r_ack, r_timeout, r_bank_write;
  logic [15:0]          r_rdata, r_bank_wdata;
  logic [NUM_BANKS-1:0] r_bank_req;
  logic [24:0]          r_bank_word;

  logic                 w_go, w_write, w_pref, w_valid, w_hit;
  logic [24:0]          w_word;
  logic [3:0]           w_bank;
  logic [15:0]          w_wdata, w_sel_data;
  logic                 w_sel_ack, w_expire, w_do_pf;
  logic [7:0]           w_cnt_inc;
  logic                 w_unused_addr0;

  function automatic logic [NUM_BANKS-1:0] bank_onehot(input logic [3:0] bank);
    bank_onehot = '0;
    for (int b = 0; b < NUM_BANKS; b++) bank_onehot[b] = (32'(bank) == b);
  endfunction

  // A request latched during a prefetch is replayed from the held fields once back in idle.
  assign w_go    = i_request | r_pend;
  assign w_write = r_pend ? r_write : i_write;
  assign w_word  = r_pend ? r_word : i_address[25:1];
  assign w_bank  = r_pend ? r_bank : i_bank;
  assign w_pref  = r_pend ? r_pref : i_prefetch;
  assign w_wdata = r_pend ? r_wdata : i_wdata;
  assign w_valid = (32'(w_bank) < NUM_BANKS);
  assign w_hit   = !w_write && w_valid && r_buf_valid && (r_buf_bank == w_bank) &&
                   (r_buf_word == w_word);
  assign w_unused_addr0 = i_address[0];

  always_comb begin
    w_sel_ack  = 1'b0;
    w_sel_data = '0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      if (32'(r_sel) == b) begin
        w_sel_ack  = i_bank_ack[b];
        w_sel_data = i_bank_rdata[16*b +: 16];
      end
    end
  end

  assign w_cnt_inc = r_cnt + 8'd1;
  assign w_expire  = !w_sel_ack && (w_cnt_inc == TimeoutCnt);
  // Misses complete straight out of ACCESS so o_ack lands one cycle after the bank ack.
  assign w_do_pf   = !r_write && r_pref && !r_inv &&
                     ((r_state == StRespond) || ((r_state == StAccess) && w_sel_ack));

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) r_state <= StIdle;
    else            r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      StIdle: begin
        if (w_go) w_state_next = (!w_valid || w_hit) ? StRespond : StAccess;
      end
      StAccess: begin
        if (w_sel_ack || w_expire) w_state_next = w_do_pf ? StPrefetch : StIdle;
      end
      StRespond: w_state_next = w_do_pf ? StPrefetch : StIdle;
      StPrefetch: begin
        if (w_sel_ack || w_expire) w_state_next = StIdle;
      end
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_pend       <= 1'b0;
      r_write      <= 1'b0;
      r_pref       <= 1'b0;
      r_inv        <= 1'b0;
      r_word       <= '0;
      r_bank       <= '0;
      r_sel        <= '0;
      r_wdata      <= '0;
      r_resp_data  <= '0;
      r_cnt        <= '0;
      r_buf_valid  <= 1'b0;
      r_buf_bank   <= '0;
      r_buf_word   <= '0;
      r_buf_data   <= '0;
      r_ack        <= 1'b0;
      r_timeout    <= 1'b0;
      r_rdata      <= '0;
      r_bank_req   <= '0;
      r_bank_write <= 1'b0;
      r_bank_word  <= '0;
      r_bank_wdata <= '0;
    end else begin
      r_ack     <= 1'b0;
      r_timeout <= 1'b0;
      case (r_state)
        StIdle: begin
          if (w_go) begin
            r_pend  <= 1'b0;
            r_write <= w_write;
            r_word  <= w_word;
            r_bank  <= w_bank;
            r_pref  <= w_pref;
            r_wdata <= w_wdata;
            r_sel   <= w_bank;
            r_inv   <= !w_valid;
            r_cnt   <= '0;
            if (!w_valid) begin
              r_resp_data <= 16'h0000;
            end else if (w_hit) begin
              r_resp_data <= r_buf_data;
            end else begin
              r_bank_req   <= bank_onehot(w_bank);
              r_bank_write <= w_write;
              r_bank_word  <= w_word;
              r_bank_wdata <= w_wdata;
              if (w_write) r_buf_valid <= 1'b0;
            end
          end
        end
        StAccess: begin
          r_cnt <= w_cnt_inc;
          if (w_sel_ack || w_expire) begin
            r_ack        <= 1'b1;
            r_timeout    <= w_expire;
            r_bank_req   <= '0;
            r_bank_write <= 1'b0;
            if (w_expire)      r_rdata <= 16'hFFFF;
            else if (!r_write) r_rdata <= w_sel_data;
          end
        end
        StRespond: begin
          r_ack   <= 1'b1;
          r_rdata <= r_resp_data;
        end
        StPrefetch: begin
          r_cnt <= w_cnt_inc;
          if (i_request) begin
            r_pend  <= 1'b1;
            r_write <= i_write;
            r_word  <= i_address[25:1];
            r_bank  <= i_bank;
            r_pref  <= i_prefetch;
            r_wdata <= i_wdata;
          end
          if (w_sel_ack || w_expire) begin
            r_bank_req  <= '0;
            r_buf_valid <= w_sel_ack;
            if (w_sel_ack) begin
              r_buf_bank <= r_sel;
              r_buf_word <= r_bank_word;
              r_buf_data <= w_sel_data;
            end
          end
        end
        default: ;
      endcase
      // Launching the next-word fetch overrides the request drop done above.
      if (w_do_pf) begin
        r_bank_req   <= bank_onehot(r_sel);
        r_bank_write <= 1'b0;
        r_bank_word  <= r_word + 25'd1;
        r_cnt        <= '0;
      end
    end
  end

  assign o_ack          = r_ack;
  assign o_rdata        = r_rdata;
  assign o_timeout      = r_timeout;
  assign o_bank_request = r_bank_req;
  assign o_bank_write   = r_bank_write;
  assign o_bank_address = {r_bank_word, 1'b0};
  assign o_bank_wdata   = r_bank_wdata;

endmodule

// File: tb/tb_n64_bank_responder.sv
// Directed bench for n64_bank_responder: misses, prefetch hits, writes, invalid bank,
// timeout, address wrap, pending request during prefetch and reset mid-access.
module tb_n64_bank_responder;

  localparam int unsigned NB = 4;

  logic          clk;
  logic          rst_n;
  logic          request;
  logic          write;
  logic [25:0]   address;
  logic [3:0]    bank;
  logic          prefetch;
  logic [15:0]   wdata;
  logic          ack;
  logic [15:0]   rdata;
  logic          timeout;
  logic [NB-1:0] bank_req;
  logic          bank_write;
  logic [25:0]   bank_addr;
  logic [15:0]   bank_wdata;
  logic [NB-1:0] bank_ack;
  logic [16*NB-1:0] bank_rdata;

  int n_cmp = 0;
  int n_err = 0;

  n64_bank_responder #(
    .NUM_BANKS      (NB),
    .TIMEOUT_CYCLES (8)
  ) u_dut (
    .i_clk          (clk),
    .i_reset_n      (rst_n),
    .i_request      (request),
    .i_write        (write),
    .i_address      (address),
    .i_bank         (bank),
    .i_prefetch     (prefetch),
    .i_wdata        (wdata),
    .o_ack          (ack),
    .o_rdata        (rdata),
    .o_timeout      (timeout),
    .o_bank_request (bank_req),
    .o_bank_write   (bank_write),
    .o_bank_address (bank_addr),
    .o_bank_wdata   (bank_wdata),
    .i_bank_ack     (bank_ack),
    .i_bank_rdata   (bank_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic wr, input logic [25:0] addr, input logic [3:0] bk,
                       input logic pf, input logic [15:0] wd);
    request  = 1'b1;
    write    = wr;
    address  = addr;
    bank     = bk;
    prefetch = pf;
    wdata    = wd;
    tick();
    request  = 1'b0;
  endtask

  task automatic give_ack(input int bk, input logic [15:0] data);
    bank_ack[bk]            = 1'b1;
    bank_rdata[16*bk +: 16] = data;
    tick();
    bank_ack = '0;
  endtask

  initial begin
    int hi_cycles;
    rst_n = 1'b0; request = 1'b0; write = 1'b0; address = '0; bank = '0;
    prefetch = 1'b0; wdata = '0; bank_ack = '0; bank_rdata = '0;
    repeat (2) tick();
    check_eq("rst_ack", ack, 0);
    check_eq("rst_req", bank_req, 0);
    check_eq("rst_rdata", rdata, 0);
    rst_n = 1'b1;
    tick();

    // T1: miss on bank0, ack on the third cycle, then prefetch of next word
    issue(0, 26'h0000100, 0, 1, 0);
    check_eq("t1_req", bank_req, 4'b0001);
    check_eq("t1_addr", bank_addr, 26'h0000100);
    check_eq("t1_wr", bank_write, 0);
    tick();
    tick();
    give_ack(0, 16'hBEEF);
    check_eq("t1_ack", ack, 1);
    check_eq("t1_rdata", rdata, 16'hBEEF);
    check_eq("t1_to", timeout, 0);
    check_eq("t1_pf_req", bank_req, 4'b0001);
    check_eq("t1_pf_addr", bank_addr, 26'h0000102);
    check_eq("t1_pf_wr", bank_write, 0);

    // T2: prefetch fills 0x1234, sequential read hits
    give_ack(0, 16'h1234);
    check_eq("t2_fill_noack", ack, 0);
    check_eq("t2_fill_req", bank_req, 0);
    issue(0, 26'h0000102, 0, 1, 0);
    check_eq("t2_hit_noreq", bank_req, 0);
    check_eq("t2_hit_early", ack, 0);
    tick();
    check_eq("t2_hit_ack", ack, 1);
    check_eq("t2_hit_rdata", rdata, 16'h1234);
    check_eq("t2_pf_req", bank_req, 4'b0001);
    check_eq("t2_pf_addr", bank_addr, 26'h0000104);

    // T3: buffer holds 0x104, a write there invalidates it
    give_ack(0, 16'h5678);
    issue(1, 26'h0000104, 0, 1, 16'h5555);
    check_eq("t3_wr_req", bank_req, 4'b0001);
    check_eq("t3_wr_strobe", bank_write, 1);
    check_eq("t3_wr_data", bank_wdata, 16'h5555);
    check_eq("t3_wr_addr", bank_addr, 26'h0000104);
    give_ack(0, 16'h0000);
    check_eq("t3_wr_ack", ack, 1);
    check_eq("t3_wr_nopf", bank_req, 0);
    issue(0, 26'h0000104, 0, 0, 0);
    check_eq("t3_rd_miss", bank_req, 4'b0001);
    give_ack(0, 16'h5555);
    check_eq("t3_rd_ack", ack, 1);
    check_eq("t3_rd_data", rdata, 16'h5555);

    // T4: invalid bank
    issue(0, 26'h0000040, 4'hF, 1, 0);
    check_eq("t4_noreq", bank_req, 0);
    check_eq("t4_held", rdata, 16'h5555);
    check_eq("t4_early", ack, 0);
    tick();
    check_eq("t4_ack", ack, 1);
    check_eq("t4_rdata", rdata, 16'h0000);
    check_eq("t4_noreq2", bank_req, 0);
    tick();
    check_eq("t4_pulse", ack, 0);

    // T5: bank2 silent, request must drop after 8 cycles
    issue(0, 26'h0000300, 2, 1, 0);
    hi_cycles = 0;
    while (bank_req == 4'b0100 && hi_cycles < 20) begin
      hi_cycles++;
      tick();
    end
    check_eq("t5_cycles", hi_cycles, 8);
    check_eq("t5_ack", ack, 1);
    check_eq("t5_to", timeout, 1);
    check_eq("t5_rdata", rdata, 16'hFFFF);
    check_eq("t5_nopf", bank_req, 0);
    tick();
    check_eq("t5_to_pulse", timeout, 0);

    // Address wrap and bit 0 ignored
    issue(0, 26'h3FFFFFF, 3, 1, 0);
    check_eq("wrap_addr", bank_addr, 26'h3FFFFFE);
    give_ack(3, 16'h1111);
    check_eq("wrap_rdata", rdata, 16'h1111);
    check_eq("wrap_pf_addr", bank_addr, 26'h0000000);
    check_eq("wrap_pf_req", bank_req, 4'b1000);
    give_ack(3, 16'h2222);

    // T6: request arrives during prefetch, served from the fresh buffer
    issue(0, 26'h0000200, 1, 1, 0);
    give_ack(1, 16'hAAAA);
    check_eq("t6_rdata", rdata, 16'hAAAA);
    check_eq("t6_pf_addr", bank_addr, 26'h0000202);
    issue(0, 26'h0000202, 1, 1, 0);
    check_eq("t6_pend_req", bank_req, 4'b0010);
    check_eq("t6_pend_noack", ack, 0);
    give_ack(1, 16'hCAFE);
    check_eq("t6_fill_noack", ack, 0);
    tick();
    check_eq("t6_eval_noack", ack, 0);
    tick();
    check_eq("t6_pend_ack", ack, 1);
    check_eq("t6_pend_data", rdata, 16'hCAFE);
    check_eq("t6_pf2_addr", bank_addr, 26'h0000204);
    give_ack(1, 16'hD00D);
    issue(0, 26'h0000206, 1, 0, 0);
    check_eq("t6_acc_req", bank_req, 4'b0010);
    #2 rst_n = 1'b0;
    #1;
    check_eq("t6_rst_req", bank_req, 0);
    check_eq("t6_rst_addr", bank_addr, 0);
    check_eq("t6_rst_rdata", rdata, 0);
    check_eq("t6_rst_ack", ack, 0);
    tick();
    rst_n = 1'b1;
    tick();
    check_eq("t6_post_ack", ack, 0);
    check_eq("t6_post_req", bank_req, 0);
    issue(0, 26'h0000204, 1, 0, 0);
    check_eq("t6_miss_req", bank_req, 4'b0010);
    give_ack(1, 16'h4321);
    check_eq("t6_miss_ack", ack, 1);
    check_eq("t6_miss_data", rdata, 16'h4321);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
